// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX and TX buffering paths.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef struct packed {
        logic                   perr;
        logic [UART_DATA_W-1:0] data;
    } uart_rx_entry_t;

endpackage

// File: rtl/uart_fifo_core.sv
// Generic synchronous FIFO with show-ahead read; shared by the UART RX and TX paths.
module uart_fifo_core #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    // Pointers carry one extra wrap bit so equal low bits can mean either full or empty.
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (count_o == FULL_CNT);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: edge-captures characters with their parity flag and flags overrun.
// Optional occupancy threshold interrupt is built when UART_RX_FIFO_THRESH_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      i_rx_data,
    input  logic                   i_rx_done,
    input  logic                   i_parity_err,
    input  logic                   i_rd_en,
    input  logic                   i_clr_overrun,
`ifdef UART_RX_FIFO_THRESH_EN
    input  logic [$clog2(DEPTH):0] i_thresh,
    output logic                   o_thresh_irq,
`endif
    output logic [DATA_W-1:0]      o_rd_data,
    output logic                   o_rd_perr,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overrun
);

    logic            done_q;
    logic            wr_stb;
    logic            drop;
    logic            overrun_q, overrun_d;
    logic [DATA_W:0] head;

    assign wr_stb = i_rx_done & ~done_q;
    // A full FIFO is never empty, so any read this cycle frees the slot the write needs.
    assign drop   = wr_stb & o_full & ~i_rd_en;

    always_comb begin
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (i_clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // done_q resets high so a level already present at reset release is not a new character.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q    <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            done_q    <= i_rx_done;
            overrun_q <= overrun_d;
        end
    end

    uart_fifo_core #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_stb),
        .pop_i   (i_rd_en),
        .wdata_i ({i_parity_err, i_rx_data}),
        .rdata_o (head),
        .empty_o (o_empty),
        .full_o  (o_full),
        .count_o (o_count)
    );

    assign o_rd_data = o_empty ? '0 : head[DATA_W-1:0];
    assign o_rd_perr = o_empty ? 1'b0 : head[DATA_W];
    assign o_overrun = overrun_q;

`ifdef UART_RX_FIFO_THRESH_EN
    logic thresh_q, thresh_d;

    assign thresh_d = (i_thresh != '0) && (o_count >= i_thresh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh_q <= 1'b0;
        end else begin
            thresh_q <= thresh_d;
        end
    end

    assign o_thresh_irq = thresh_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, DATA_W=8).
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       i_parity_err;
    logic       i_rd_en;
    logic       i_clr_overrun;
    logic [7:0] o_rd_data;
    logic       o_rd_perr;
    logic       o_empty;
    logic       o_full;
    logic [4:0] o_count;
    logic       o_overrun;
`ifdef UART_RX_FIFO_THRESH_EN
    logic [4:0] i_thresh;
    logic       o_thresh_irq;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(16), .DATA_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_rx_data     (i_rx_data),
        .i_rx_done     (i_rx_done),
        .i_parity_err  (i_parity_err),
        .i_rd_en       (i_rd_en),
        .i_clr_overrun (i_clr_overrun),
`ifdef UART_RX_FIFO_THRESH_EN
        .i_thresh      (i_thresh),
        .o_thresh_irq  (o_thresh_irq),
`endif
        .o_rd_data     (o_rd_data),
        .o_rd_perr     (o_rd_perr),
        .o_empty       (o_empty),
        .o_full        (o_full),
        .o_count       (o_count),
        .o_overrun     (o_overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_char(input logic [7:0] d, input logic p);
        i_rx_data    = d;
        i_parity_err = p;
        i_rx_done    = 1'b1;
        tick();
        i_rx_done    = 1'b0;
        tick();
    endtask

    task automatic pop();
        i_rd_en = 1'b1;
        tick();
        i_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_rx_data = 8'h00; i_rx_done = 1'b1; i_parity_err = 1'b0;
        i_rd_en = 1'b0; i_clr_overrun = 1'b0;
`ifdef UART_RX_FIFO_THRESH_EN
        i_thresh = 5'd0;
`endif
        tick(); tick();
        total++;
        if (o_empty !== 1'b1 || o_full !== 1'b0 || o_count !== 5'd0 || o_overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got empty=%b full=%b count=%0d ovr=%b want 1 0 0 0",
                     o_empty, o_full, o_count, o_overrun);
        end
        total++;
        if (o_rd_data !== 8'h00 || o_rd_perr !== 1'b0) begin
            bad++;
            $display("FAIL reset_rd_data got %h/%b want 00/0", o_rd_data, o_rd_perr);
        end
        rst = 1'b0;
        tick(); tick();
        total++;
        if (o_count !== 5'd0) begin
            bad++;
            $display("FAIL done_high_at_release got count=%0d want 0", o_count);
        end
        i_rx_done = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [3];
        logic       exp_p [3];
        exp_d[0] = 8'h1F; exp_p[0] = 1'b0;
        exp_d[1] = 8'h55; exp_p[1] = 1'b1;
        exp_d[2] = 8'hAA; exp_p[2] = 1'b0;
        for (int i = 0; i < 3; i++) write_char(exp_d[i], exp_p[i]);
        total++;
        if (o_count !== 5'd3 || o_empty !== 1'b0) begin
            bad++;
            $display("FAIL basic_count got count=%0d empty=%b want 3 0", o_count, o_empty);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (o_rd_data !== exp_d[i] || o_rd_perr !== exp_p[i]) begin
                bad++;
                $display("FAIL basic_read%0d got %h/%b want %h/%b", i, o_rd_data, o_rd_perr,
                         exp_d[i], exp_p[i]);
            end
            pop();
        end
        total++;
        if (o_empty !== 1'b1 || o_count !== 5'd0) begin
            bad++;
            $display("FAIL basic_empty got empty=%b count=%0d want 1 0", o_empty, o_count);
        end
    endtask

    task automatic test_long_pulse();
        i_rx_data = 8'h3C; i_parity_err = 1'b0; i_rx_done = 1'b1;
        tick();
        total++;
        if (o_count !== 5'd1) begin
            bad++;
            $display("FAIL pulse_latency got count=%0d want 1", o_count);
        end
        for (int i = 0; i < 4; i++) tick();
        i_rx_done = 1'b0;
        tick();
        total++;
        if (o_count !== 5'd1 || o_rd_data !== 8'h3C) begin
            bad++;
            $display("FAIL long_pulse got count=%0d data=%h want 1 3c", o_count, o_rd_data);
        end
        pop();
    endtask

    task automatic test_full_overrun();
        for (int i = 0; i < 16; i++) write_char(8'(i), 1'b0);
        total++;
        if (o_full !== 1'b1 || o_count !== 5'd16 || o_overrun !== 1'b0) begin
            bad++;
            $display("FAIL fill got full=%b count=%0d ovr=%b want 1 16 0", o_full, o_count, o_overrun);
        end
        i_rx_data = 8'hEE; i_rx_done = 1'b1;
        tick();
        total++;
        if (o_overrun !== 1'b1 || o_full !== 1'b1 || o_count !== 5'd16) begin
            bad++;
            $display("FAIL overrun_set got ovr=%b full=%b count=%0d want 1 1 16", o_overrun, o_full, o_count);
        end
        i_rx_done = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            total++;
            if (o_rd_data !== 8'(i)) begin
                bad++;
                $display("FAIL overrun_read%0d got %h want %h", i, o_rd_data, 8'(i));
            end
            pop();
        end
        total++;
        if (o_empty !== 1'b1 || o_overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_sticky got empty=%b ovr=%b want 1 1", o_empty, o_overrun);
        end
        i_clr_overrun = 1'b1;
        tick();
        i_clr_overrun = 1'b0;
        total++;
        if (o_overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clear got %b want 0", o_overrun);
        end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 16; i++) write_char(8'h10 + 8'(i), 1'b0);
        i_rx_data = 8'h77; i_rx_done = 1'b1; i_rd_en = 1'b1;
        tick();
        i_rx_done = 1'b0; i_rd_en = 1'b0;
        tick();
        total++;
        if (o_count !== 5'd16 || o_full !== 1'b1 || o_overrun !== 1'b0) begin
            bad++;
            $display("FAIL simul_full got count=%0d full=%b ovr=%b want 16 1 0", o_count, o_full, o_overrun);
        end
        i_rx_data = 8'h99; i_rx_done = 1'b1; i_clr_overrun = 1'b1;
        tick();
        i_rx_done = 1'b0; i_clr_overrun = 1'b0;
        total++;
        if (o_overrun !== 1'b1) begin
            bad++;
            $display("FAIL set_beats_clear got ovr=%b want 1", o_overrun);
        end
        i_clr_overrun = 1'b1;
        tick();
        i_clr_overrun = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp;
            exp = (i == 15) ? 8'h77 : 8'h11 + 8'(i);
            total++;
            if (o_rd_data !== exp) begin
                bad++;
                $display("FAIL simul_read%0d got %h want %h", i, o_rd_data, exp);
            end
            pop();
        end
    endtask

    task automatic test_empty_read_reset();
        pop();
        total++;
        if (o_count !== 5'd0 || o_empty !== 1'b1) begin
            bad++;
            $display("FAIL empty_read got count=%0d empty=%b want 0 1", o_count, o_empty);
        end
        write_char(8'hA1, 1'b1);
        total++;
        if (o_rd_data !== 8'hA1 || o_rd_perr !== 1'b1) begin
            bad++;
            $display("FAIL after_empty_read got %h/%b want a1/1", o_rd_data, o_rd_perr);
        end
        for (int i = 0; i < 3; i++) write_char(8'hB0 + 8'(i), 1'b0);
        total++;
        if (o_count !== 5'd4) begin
            bad++;
            $display("FAIL four_held got count=%0d want 4", o_count);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (o_empty !== 1'b1 || o_count !== 5'd0) begin
            bad++;
            $display("FAIL async_reset got empty=%b count=%0d want 1 0", o_empty, o_count);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

`ifdef UART_RX_FIFO_THRESH_EN
    task automatic test_thresh();
        i_thresh = 5'd4;
        for (int i = 0; i < 3; i++) write_char(8'hC0 + 8'(i), 1'b0);
        i_rx_data = 8'hC3; i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        total++;
        if (o_count !== 5'd4 || o_thresh_irq !== 1'b0) begin
            bad++;
            $display("FAIL thresh_pre got count=%0d irq=%b want 4 0", o_count, o_thresh_irq);
        end
        tick();
        total++;
        if (o_thresh_irq !== 1'b1) begin
            bad++;
            $display("FAIL thresh_rise got irq=%b want 1", o_thresh_irq);
        end
        pop();
        total++;
        if (o_count !== 5'd3 || o_thresh_irq !== 1'b1) begin
            bad++;
            $display("FAIL thresh_hold got count=%0d irq=%b want 3 1", o_count, o_thresh_irq);
        end
        tick();
        total++;
        if (o_thresh_irq !== 1'b0) begin
            bad++;
            $display("FAIL thresh_fall got irq=%b want 0", o_thresh_irq);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_long_pulse();
        test_full_overrun();
        test_full_simul();
        test_empty_read_reset();
`ifdef UART_RX_FIFO_THRESH_EN
        test_thresh();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
